minmax_tracker_4: RTL and testbench

- Streaming consumer of 4-bit samples that tracks the running maximum and running minimum since the last clear.
- Uses two comb_comp_4 instances:
  - one compares the incoming sample against the stored max;
  - one compares the incoming sample against the stored min.
- The comparators' gt/lt outputs drive the register updates.
- Sits downstream of the sample source and provides registered extrema and event pulses to status logic.

---
 rtl/minmax_tracker_4_pkg.sv | 10 +
 rtl/comb_comp_4.sv | 17 +
 rtl/minmax_tracker_4.sv | 111 +++++++++++
 tb/tb_minmax_tracker_4.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/minmax_tracker_4_pkg.sv
// minmax_tracker_4_pkg: shared state encoding and reset constants for the extrema tracker
package minmax_tracker_4_pkg;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    localparam logic [3:0] MAX_RST = 4'h0;
    localparam logic [3:0] MIN_RST = 4'hF;

endpackage

// File: rtl/comb_comp_4.sv
// comb_comp_4: unsigned 4-bit magnitude comparator (a vs b)
module comb_comp_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    // Purely combinational relation of a to b
    always_comb begin
        gt = a > b;
        eq = a == b;
        lt = a < b;
    end

endmodule

// File: rtl/minmax_tracker_4.sv
// minmax_tracker_4: running max/min of a 4-bit sample stream with event pulses and saturating count
module minmax_tracker_4
    import minmax_tracker_4_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             in_ready,
    output logic [3:0]       max_out,
    output logic [3:0]       min_out,
    output logic             have_data,
    output logic             new_max,
    output logic             new_min,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [3:0]       max_q, max_d;
    logic [3:0]       min_q, min_d;
    logic             new_max_q, new_max_d;
    logic             new_min_q, new_min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             max_gt;
    logic             min_lt;

    comb_comp_4 u_cmp_max (
        .a  (in_data),
        .b  (max_q),
        .gt (max_gt),
        .eq (),
        .lt ()
    );

    comb_comp_4 u_cmp_min (
        .a  (in_data),
        .b  (min_q),
        .gt (),
        .eq (),
        .lt (min_lt)
    );

    assign in_ready = !clr;
    assign accept   = in_valid && in_ready;

    // Next-state: clr wins over any sample; first accept seeds both extrema, later ones compare
    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        min_d     = min_q;
        cnt_d     = cnt_q;
        new_max_d = 1'b0;
        new_min_d = 1'b0;
        if (clr) begin
            state_d = ST_EMPTY;
            max_d   = MAX_RST;
            min_d   = MIN_RST;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = ST_TRACK;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            if (state_q == ST_EMPTY) begin
                max_d     = in_data;
                min_d     = in_data;
                new_max_d = 1'b1;
                new_min_d = 1'b1;
            end else begin
                max_d     = max_gt ? in_data : max_q;
                min_d     = min_lt ? in_data : min_q;
                new_max_d = max_gt;
                new_min_d = min_lt;
            end
        end
    end

    // State registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            max_q     <= MAX_RST;
            min_q     <= MIN_RST;
            cnt_q     <= '0;
            new_max_q <= 1'b0;
            new_min_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            min_q     <= min_d;
            cnt_q     <= cnt_d;
            new_max_q <= new_max_d;
            new_min_q <= new_min_d;
        end
    end

    assign max_out    = max_q;
    assign min_out    = min_q;
    assign have_data  = state_q == ST_TRACK;
    assign new_max    = new_max_q;
    assign new_min    = new_min_q;
    assign sample_cnt = cnt_q;
    assign cnt_sat    = cnt_q == CNT_MAX;

endmodule

// File: tb/tb_minmax_tracker_4.sv
// tb_minmax_tracker_4: table-driven scoreboard bench for minmax_tracker_4 (CNT_W=3)
module tb_minmax_tracker_4;

    localparam int CW = 3;

    typedef struct {
        logic          clr;
        logic          vld;
        logic [3:0]    d;
        logic [3:0]    emax;
        logic [3:0]    emin;
        logic          ehave;
        logic          enmax;
        logic          enmin;
        logic [CW-1:0] ecnt;
        logic          esat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [3:0]    in_data = 4'h0;
    logic          in_ready;
    logic [3:0]    max_out;
    logic [3:0]    min_out;
    logic          have_data;
    logic          new_max;
    logic          new_min;
    logic [CW-1:0] sample_cnt;
    logic          cnt_sat;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    vec_t vecs[$];
    vec_t sb[$];

    minmax_tracker_4 #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .max_out    (max_out),
        .min_out    (min_out),
        .have_data  (have_data),
        .new_max    (new_max),
        .new_min    (new_min),
        .sample_cnt (sample_cnt),
        .cnt_sat    (cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic c, input logic v, input logic [3:0] d,
                                input logic [3:0] mx, input logic [3:0] mn, input logic h,
                                input logic px, input logic pn, input int cnt, input logic s);
        vec_t r;
        r.clr = c; r.vld = v; r.d = d; r.emax = mx; r.emin = mn; r.ehave = h;
        r.enmax = px; r.enmin = pn; r.ecnt = CW'(cnt); r.esat = s;
        return r;
    endfunction

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, ".max"}, max_out, e.emax);
        chk({tag, ".min"}, min_out, e.emin);
        chk({tag, ".have"}, have_data, e.ehave);
        chk({tag, ".new_max"}, new_max, e.enmax);
        chk({tag, ".new_min"}, new_min, e.enmin);
        chk({tag, ".cnt"}, sample_cnt, e.ecnt);
        chk({tag, ".sat"}, cnt_sat, e.esat);
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        clr = v.clr; in_valid = v.vld; in_data = v.d;
        #1 chk({tag, ".in_ready"}, in_ready, !v.clr);
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
    endtask

    initial begin
        vec_t rv;
        // idle after reset
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0));
        // stream 5,9,2,9,0
        vecs.push_back(mk(0, 1, 4'd5, 4'd5, 4'd5, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'd9, 4'd9, 4'd5, 1, 1, 0, 2, 0));
        vecs.push_back(mk(0, 1, 4'd2, 4'd9, 4'd2, 1, 0, 1, 3, 0));
        vecs.push_back(mk(0, 1, 4'd9, 4'd9, 4'd2, 1, 0, 0, 4, 0));
        vecs.push_back(mk(0, 1, 4'd0, 4'd9, 4'd0, 1, 0, 1, 5, 0));
        // clr with a colliding sample, then F seeds both
        vecs.push_back(mk(1, 1, 4'd7, 4'h0, 4'hF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'hF, 4'hF, 4'hF, 1, 1, 1, 1, 0));
        // gaps: 3, idle, idle, 12
        vecs.push_back(mk(1, 0, 4'd0, 4'h0, 4'hF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd3, 4'd3, 4'd3, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 4'd15, 4'd3, 4'd3, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 4'd0, 4'd3, 4'd3, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 4'd12, 4'd12, 4'd3, 1, 1, 0, 2, 0));
        // saturation: 10 samples with CNT_W=3
        vecs.push_back(mk(1, 0, 4'd0, 4'h0, 4'hF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'd5, 4'd5, 4'd5, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'd4, 4'd5, 4'd4, 1, 0, 1, 2, 0));
        vecs.push_back(mk(0, 1, 4'd6, 4'd6, 4'd4, 1, 1, 0, 3, 0));
        vecs.push_back(mk(0, 1, 4'd3, 4'd6, 4'd3, 1, 0, 1, 4, 0));
        vecs.push_back(mk(0, 1, 4'd7, 4'd7, 4'd3, 1, 1, 0, 5, 0));
        vecs.push_back(mk(0, 1, 4'd2, 4'd7, 4'd2, 1, 0, 1, 6, 0));
        vecs.push_back(mk(0, 1, 4'd8, 4'd8, 4'd2, 1, 1, 0, 7, 1));
        vecs.push_back(mk(0, 1, 4'd1, 4'd8, 4'd1, 1, 0, 1, 7, 1));
        vecs.push_back(mk(0, 1, 4'd8, 4'd8, 4'd1, 1, 0, 0, 7, 1));
        vecs.push_back(mk(0, 1, 4'd14, 4'd14, 4'd1, 1, 1, 0, 7, 1));
        // boundary: repeated F at max, repeated 0 at min
        vecs.push_back(mk(0, 1, 4'hF, 4'hF, 4'd1, 1, 1, 0, 7, 1));
        vecs.push_back(mk(0, 1, 4'hF, 4'hF, 4'd1, 1, 0, 0, 7, 1));
        vecs.push_back(mk(0, 1, 4'h0, 4'hF, 4'h0, 1, 0, 1, 7, 1));
        vecs.push_back(mk(0, 1, 4'h0, 4'hF, 4'h0, 1, 0, 0, 7, 1));
        // first sample after clr equal to reset value 0
        vecs.push_back(mk(1, 0, 4'd0, 4'h0, 4'hF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 1, 1, 1, 1, 0));

        // reset state
        #12;
        check_outputs("reset", mk(0, 0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

        // asynchronous reset between edges, mid-stream
        step(mk(0, 1, 4'd10, 4'd10, 4'd0, 1, 1, 0, 2, 0), "pre_arst");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_outputs("arst", mk(0, 0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step(mk(0, 1, 4'd6, 4'd6, 4'd6, 1, 1, 1, 1, 0), "post_arst");
        step(mk(0, 0, 4'd0, 4'd6, 4'd6, 1, 0, 0, 1, 0), "post_arst_idle");

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
